jet_feature_loader: RTL



---
 rtl/jet_tagger_pkg.sv | 19 +
 rtl/jet_feature_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/jet_tagger_pkg.sv
// Shared types and constants for the batchnorm jet-tagging datapath.
package jet_tagger_pkg;

    localparam int WIDTH       = 25;
    localparam int NFRAC       = 14;
    localparam int INPUT_SIZE  = 16;
    localparam int OUTPUT_SIZE = 5;
    localparam int IDX_W       = $clog2(INPUT_SIZE);

    typedef logic signed [WIDTH-1:0] feat_t;
    typedef feat_t feat_vec_t [INPUT_SIZE];

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        WAIT    = 2'd2
    } loader_state_t;

endpackage

// File: rtl/jet_feature_loader.sv
// Assembles a 16-feature frame from a valid/ready stream and hands it to the
// network in parallel, holding it until the network finishes or a watchdog fires.
module jet_feature_loader
    import jet_tagger_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  feat_t                s_data,
    input  logic                 s_last,
    output logic                 nn_start,
    output feat_vec_t            nn_data,
    input  logic                 nn_done,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 timeout,
    output logic                 busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    loader_state_t        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    feat_t                frame_buf_q [INPUT_SIZE-1];
    feat_t                frame_buf_d [INPUT_SIZE-1];
    feat_vec_t            nn_data_q, nn_data_d;
    logic                 nn_start_q, nn_start_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 timeout_q, timeout_d;
    logic                 accept;

    assign s_ready   = !reset && (state_q != WAIT);
    assign accept    = s_valid && s_ready;
    assign busy      = (state_q == WAIT);
    assign nn_start  = nn_start_q;
    assign nn_data   = nn_data_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign timeout   = timeout_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        frame_buf_d = frame_buf_q;
        nn_data_d   = nn_data_q;
        nn_start_d  = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            for (int i = 0; i < INPUT_SIZE-1; i++) begin
                                nn_data_d[i] = frame_buf_q[i];
                            end
                            nn_data_d[INPUT_SIZE-1] = s_data;
                            nn_start_d = 1'b1;
                            wd_d       = '0;
                            state_d    = WAIT;
                        end else begin
                            frame_err_d = 1'b1;
                            if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
                            state_d = DRAIN;
                        end
                    end else begin
                        frame_buf_d[idx_q] = s_data;
                        if (s_last) begin
                            // Short frame: the partial buffer is simply abandoned.
                            idx_d       = '0;
                            frame_err_d = 1'b1;
                            if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) state_d = COLLECT;
            end
            WAIT: begin
                if (nn_done) begin
                    state_d = COLLECT;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = COLLECT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            wd_q        <= '0;
            frame_buf_q <= '{default: '0};
            nn_data_q   <= '{default: '0};
            nn_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            frame_buf_q <= frame_buf_d;
            nn_data_q   <= nn_data_d;
            nn_start_q  <= nn_start_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule
